// File: rtl/led_blinker_array.sv
// led_blinker_array
//   Multi-channel, run-time configurable LED driver. One shared prescaler
//   turns CLOCK_50 into a one-cycle timebase tick. Each channel runs its own
//   OFF / ON / BLINK / ONESHOT state machine, clocked only on tick cycles,
//   with a per-channel half-period counted in ticks.
//
//   Optional feature macro: LED_PWM_EN
//     Defined:   adds the cfg_duty port, a per-channel 4-bit duty register and
//                a free-running 4-bit PWM phase counter. Each LED is gated by
//                (pcyc <= duty) before the output register.
//     Undefined: no PWM hardware; LED is the channel led state register.
module led_blinker_array #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16,
  parameter int DEF_HALF = 499
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half,
`ifdef LED_PWM_EN
  input  logic [3:0]        cfg_duty,
`endif
  output logic [NUM_CH-1:0] LED,
  output logic              tick
);

  // Prescaler counter width; at least one bit even for tiny PRESCALE values.
  localparam int                PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]     P_LAST   = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]     P_ONE    = PW'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  HALF_RST = CNT_W'(DEF_HALF);

  // Channel operating mode; encoding matches the cfg_mode field.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------
  // Shared prescaler / timebase
  // ---------------------------------------------------------------------
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick_q, tick_d;

  // Prescaler next state: wrap at PRESCALE-1 and raise tick for one cycle.
  always_comb begin
    pcnt_d = pcnt_q;
    tick_d = 1'b0;
    if (pcnt_q == P_LAST) begin
      pcnt_d = '0;
      tick_d = 1'b1;
    end else begin
      pcnt_d = pcnt_q + P_ONE;
      tick_d = 1'b0;
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  // ---------------------------------------------------------------------
  // Per-channel state machines
  // ---------------------------------------------------------------------
  mode_e              mode_q [NUM_CH];
  mode_e              mode_d [NUM_CH];
  logic [CNT_W-1:0]   half_q [NUM_CH];
  logic [CNT_W-1:0]   half_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q  [NUM_CH];
  logic [CNT_W-1:0]   cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]  led_q, led_d;
  logic [NUM_CH-1:0]  wr_hit_s;

  // Decode which channel (if any) the config port is writing this cycle.
  // Out-of-range cfg_ch values match no channel, so the write is dropped.
  always_comb begin
    wr_hit_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        wr_hit_s[i] = 1'b1;
      end else begin
        wr_hit_s[i] = 1'b0;
      end
    end
  end

  // Channel next state: a config write beats a same-cycle tick; otherwise a
  // tick advances the mode's counter. The >= compare keeps cnt bounded even
  // if it were ever found above half.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
      led_d[i]  = led_q[i];
      if (wr_hit_s[i]) begin
        mode_d[i] = mode_e'(cfg_mode);
        half_d[i] = cfg_half;
        cnt_d[i]  = '0;
        led_d[i]  = (cfg_mode != 2'b00);
      end else if (tick_q) begin
        case (mode_q[i])
          MODE_OFF: begin
            cnt_d[i] = '0;
            led_d[i] = 1'b0;
          end
          MODE_ON: begin
            cnt_d[i] = '0;
            led_d[i] = 1'b1;
          end
          MODE_BLINK: begin
            if (cnt_q[i] >= half_q[i]) begin
              cnt_d[i] = '0;
              led_d[i] = ~led_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
              led_d[i] = led_q[i];
            end
          end
          MODE_ONESHOT: begin
            if (cnt_q[i] >= half_q[i]) begin
              cnt_d[i]  = '0;
              led_d[i]  = 1'b0;
              mode_d[i] = MODE_OFF;
            end else begin
              cnt_d[i]  = cnt_q[i] + CNT_ONE;
              led_d[i]  = 1'b1;
            end
          end
          default: begin
            mode_d[i] = MODE_OFF;
            cnt_d[i]  = '0;
            led_d[i]  = 1'b0;
          end
        endcase
      end else begin
        mode_d[i] = mode_q[i];
        half_d[i] = half_q[i];
        cnt_d[i]  = cnt_q[i];
        led_d[i]  = led_q[i];
      end
    end
  end

  // Channel state registers; reset returns every channel to OFF with the
  // default half-period.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= MODE_OFF;
        half_q[i] <= HALF_RST;
        cnt_q[i]  <= '0;
      end
      led_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= mode_d[i];
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      led_q <= led_d;
    end
  end

`ifdef LED_PWM_EN
  // ---------------------------------------------------------------------
  // Brightness PWM
  // ---------------------------------------------------------------------
  logic [3:0]        duty_q [NUM_CH];
  logic [3:0]        duty_d [NUM_CH];
  logic [3:0]        pcyc_q, pcyc_d;
  logic [NUM_CH-1:0] led_out_q, led_out_d;

  // PWM next state. The output register is fed from next-state values so
  // that LED in a given cycle reflects that same cycle's pcyc and duty.
  always_comb begin
    pcyc_d = pcyc_q + 4'd1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_hit_s[i]) begin
        duty_d[i] = cfg_duty;
      end else begin
        duty_d[i] = duty_q[i];
      end
      led_out_d[i] = led_d[i] & (pcyc_d <= duty_d[i]);
    end
  end

  // PWM phase, duty and gated output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pcyc_q <= 4'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= 4'hF;
      end
      led_out_q <= '0;
    end else begin
      pcyc_q <= pcyc_d;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= duty_d[i];
      end
      led_out_q <= led_out_d;
    end
  end

  assign LED = led_out_q;
`else
  assign LED = led_q;
`endif

endmodule

// File: tb/tb_led_blinker_array.sv
// Bench for led_blinker_array: directed scenarios followed by random config
// traffic, compared every cycle against a tick-count reference model.
module tb_led_blinker_array;

  localparam int NUM_CH   = 3;
  localparam int CH_W     = 2;
  localparam int PRESCALE = 4;
  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 3;

  logic              CLOCK_50 = 1'b0;
  logic              reset    = 1'b1;
  logic              cfg_we   = 1'b0;
  logic [CH_W-1:0]   cfg_ch   = '0;
  logic [1:0]        cfg_mode = 2'b00;
  logic [CNT_W-1:0]  cfg_half = '0;
`ifdef LED_PWM_EN
  logic [3:0]        cfg_duty = 4'hF;
`endif
  logic [NUM_CH-1:0] LED;
  logic              tick;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: per channel the mode, half and number of ticks that
  // have elapsed since the last write; LED is derived arithmetically.
  int m_mode [NUM_CH];
  int m_half [NUM_CH];
  int m_k    [NUM_CH];
  int m_edges;
  bit m_tick;

  led_blinker_array #(
    .NUM_CH  (NUM_CH),
    .CH_W    (CH_W),
    .PRESCALE(PRESCALE),
    .CNT_W   (CNT_W),
    .DEF_HALF(DEF_HALF)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_mode(cfg_mode),
    .cfg_half(cfg_half),
`ifdef LED_PWM_EN
    .cfg_duty(cfg_duty),
`endif
    .LED     (LED),
    .tick    (tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_edges = 0;
    m_tick  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = 0;
      m_half[c] = DEF_HALF;
      m_k[c]    = 0;
    end
  endfunction

  function automatic logic model_led(input int c);
    case (m_mode[c])
      0: return 1'b0;
      1: return 1'b1;
      2: return (((m_k[c] / (m_half[c] + 1)) % 2) == 0);
      3: return (m_k[c] <= m_half[c]);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] model_leds();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = model_led(c);
    return v;
  endfunction

  // Apply one rising edge to the model using the inputs present at that edge.
  function automatic void model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_we && (int'(cfg_ch) == c)) begin
        m_mode[c] = int'(cfg_mode);
        m_half[c] = int'(cfg_half);
        m_k[c]    = 0;
      end else if (m_tick) begin
        if (m_mode[c] == 2) m_k[c]++;
        if (m_mode[c] == 3) begin
          m_k[c]++;
          if (m_k[c] > m_half[c]) m_mode[c] = 0;
        end
      end
    end
    m_edges++;
    m_tick = ((m_edges % PRESCALE) == 0);
  endfunction

  task automatic step(input logic we, input int ch, input int mode, input int half, input string tag);
    @(negedge CLOCK_50);
    cfg_we   = we;
    cfg_ch   = CH_W'(ch);
    cfg_mode = 2'(mode);
    cfg_half = CNT_W'(half);
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check_eq({tag, "_led"},  32'(LED),  32'(model_leds()));
    check_eq({tag, "_tick"}, 32'(tick), 32'(m_tick));
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, tag);
  endtask

  task automatic mid_reset(input string tag);
    @(negedge CLOCK_50);
    #2 reset = 1'b1;
    #1;
    check_eq({tag, "_led_async"},  32'(LED),  32'd0);
    check_eq({tag, "_tick_async"}, 32'(tick), 32'd0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_eq({tag, "_led_held"}, 32'(LED), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    // 1: reset for three cycles, then tick cadence from release
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_eq("rst_led",  32'(LED),  32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    model_reset();
    idle(12, "t1_idle");

    // 2: ch1 BLINK half=2
    step(1'b1, 1, 2, 2, "t2_wr");
    check_eq("t2_led1_on", 32'(LED[1]), 32'd1);
    idle(40, "t2_run");

    // 3: ch2 ONESHOT half=4, then a long quiet stretch
    step(1'b1, 2, 3, 4, "t3_wr");
    idle(420, "t3_run");
    check_eq("t3_led2_off", 32'(LED[2]), 32'd0);

    // 4: write to a nonexistent channel, then reset mid-blink
    step(1'b1, 3, 1, 0, "t4_badch");
    mid_reset("t4_rst");
    idle(6, "t4_after");

    // 5: write ch0 BLINK half=1 on a tick cycle
    for (int i = 0; i < 8 && !m_tick; i++) step(1'b0, 0, 0, 0, "t5_wait");
    check_eq("t5_tick_seen", 32'(tick), 32'd1);
    step(1'b1, 0, 2, 1, "t5_wr");
    idle(24, "t5_run");

    // Random config traffic
    for (int n = 0; n < 2500; n++) begin
      int h;
      h = (($urandom % 4) == 0) ? int'($urandom % 20) : int'($urandom % 4);
      step((($urandom % 6) == 0), int'($urandom % 4), int'($urandom % 4), h, "rnd");
      if (n == 1200) mid_reset("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
